dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data RAM between the core's memory stage (CPU) and a debug/loader port (DBG).
//  - Grants one requester per cycle and drives the RAM address, write data and write-enable.
//  - CPU has priority, but a starvation counter forces a DBG slot after MAX_STREAK contested CPU grants.
//  - A halt mode gives DBG exclusive ownership of the RAM for program/data loading.
//  - Sits between memory-stage address/store-data and the RAM; the memory-to-register mux is unchanged.
// PARAMETERS
//  ADDR_W      6   RAM word-address width (64 words)
//  DATA_W      32  data width
//  MAX_STREAK  4   max consecutive CPU grants while DBG waits; legal range 1..15
// PORTS
//  i_clk         in   1       clock; everything is on the rising edge
//  i_rst         in   1       synchronous, active-high reset
//  i_cpu_req     in   1       CPU memory access this cycle
//  i_cpu_we      in   1       CPU store (1) / load (0)
//  i_cpu_addr    in   ADDR_W  CPU word address (ALU result low bits)
//  i_cpu_data    in   DATA_W  CPU store data
//  o_cpu_rdata   out  DATA_W  i_ram_data when the CPU is granted, else 0 (combinational)
//  o_cpu_stall   out  1       i_cpu_req & ~CPU grant; the core holds the PC and suppresses write-back
//  i_dbg_req     in   1       DBG access request; held with stable cmd until o_dbg_gnt
//  i_dbg_we      in   1       DBG write (1) / read (0)
//  i_dbg_addr    in   ADDR_W  DBG word address
//  i_dbg_data    in   DATA_W  DBG write data
//  i_dbg_halt    in   1       request exclusive DBG ownership (level)
//  o_dbg_gnt     out  1       DBG access performed this cycle (combinational)
//  o_dbg_rdata   out  DATA_W  registered read data for the last DBG read
//  o_dbg_rvalid  out  1       one-cycle pulse, one cycle after a DBG read grant
//  o_halted      out  1       1 while in S_HALT (registered)
//  o_ram_addr    out  ADDR_W  RAM address (granted requester, else 0)
//  o_ram_data    out  DATA_W  RAM write data (granted requester, else 0)
//  o_ram_we      out  1       granted requester's we; 0 when nothing is granted
//  i_ram_data    in   DATA_W  RAM read data (asynchronous read of o_ram_addr)
// BEHAVIOUR
//  Reset:
//  - state=S_RUN, streak=0, o_dbg_rdata=0, o_dbg_rvalid=0, o_halted=0.
//  - Combinational outputs follow from this state; o_ram_we=0 unless a request is granted that cycle.
//  FSM S_RUN:
//  - Arbitration:
//    - cpu_gnt = i_cpu_req & ~force_dbg.
//    - dbg_gnt = i_dbg_req & (~i_cpu_req | force_dbg).
//    - force_dbg = i_dbg_req & (streak == MAX_STREAK).
//  - streak counter:
//    - Increments when cpu_gnt & i_dbg_req.
//    - Clears on dbg_gnt or when ~i_dbg_req.
//    - Saturates at MAX_STREAK.
//  - Next state: S_HALT when i_dbg_halt=1.
//  FSM S_HALT:
//  - cpu_gnt=0, so o_cpu_stall=i_cpu_req.
//  - dbg_gnt=i_dbg_req.
//  - streak held at 0.
//  - Next state: S_RUN when i_dbg_halt=0.
//  - o_halted is registered: it rises and falls one cycle after state entry.
//  Transition cycle: arbitration that cycle uses the current state; halt takes effect the following cycle.
//  DBG read: on dbg_gnt & ~i_dbg_we, capture o_dbg_rdata<=i_ram_data and set o_dbg_rvalid<=1 next cycle; else rvalid<=0.
//  Writes: the RAM commits on the edge ending the grant cycle. A same-cycle read by the other requester is impossible (one grant per cycle).
//  Back-to-back DBG reads: each yields its own rvalid pulse, 1 cycle latency, full throughput.
//  Reset mid-operation: an in-flight rvalid is dropped, halt is abandoned, and the write of the reset cycle is suppressed.
//  - o_ram_we is forced to 0 while i_rst=1.
//  Boundaries:
//  - With MAX_STREAK=1, a contested CPU/DBG load alternates CPU, DBG, CPU, ...
//  - With no requests, the RAM-side outputs are all 0.
// STRUCTURE
//  - Shared package holds ADDR_W/DATA_W defaults and state encodings S_RUN=1'b0, S_HALT=1'b1.
//  - Single module; no sub-module. The request/grant mux is small enough to stay inline.
// TESTING
//  1. Reset held 2 cycles, i_cpu_req=1 we=1 -> o_ram_we=0, o_dbg_rvalid=0, o_halted=0, no RAM change.
//  2. CPU sw addr 5 data 0xDEADBEEF, then lw addr 5 -> o_cpu_rdata=0xDEADBEEF, o_cpu_stall=0.
//  3. CPU req every cycle + DBG read addr 5, MAX_STREAK=4:
//     - 4 CPU grants, then o_dbg_gnt=1 with o_cpu_stall=1 for that cycle.
//     - Next cycle o_dbg_rvalid=1, o_dbg_rdata=0xDEADBEEF.
//  4. Assert i_dbg_halt; DBG writes addr 0..3 = 0x10..0x13 while CPU requests:
//     - o_cpu_stall=1 throughout; o_halted=1 one cycle after halt.
//     - CPU lw after release returns the new values.
//  5. DBG back-to-back reads addr 1,2,3 with CPU idle -> rvalid pulses on 3 consecutive cycles with matching data.
//  6. Reset asserted the cycle after a DBG read grant -> o_dbg_rvalid=0, state=S_RUN, streak=0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter: default address and data
//   widths, the default starvation limit, the FSM state encoding and a small
//   saturating-increment helper used by the starvation counter.
package dmem_arbiter_pkg;

  localparam int DEF_ADDR_W     = 6;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MAX_STREAK = 4;
  localparam int STREAK_W       = 4;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } arb_state_t;

  // Increment v by one, but never past lim.
  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v,
                                                  input logic [STREAK_W-1:0] lim);
    if (v < lim) begin
      return v + 4'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port data RAM between the core's memory stage (CPU) and a
//   debug/loader port (DBG). One requester is granted per cycle. The CPU wins
//   contested cycles, but after MAX_STREAK consecutive contested CPU grants the
//   DBG port is forced through. A halt mode gives DBG exclusive ownership.
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cpu_req/we/addr/data       CPU access request and command
//   o_cpu_rdata                  RAM read data while the CPU is granted, else 0
//   o_cpu_stall                  CPU requested but was not granted
//   i_dbg_req/we/addr/data       DBG access request (held until o_dbg_gnt)
//   i_dbg_halt                   level request for exclusive DBG ownership
//   o_dbg_gnt                    DBG access performed this cycle
//   o_dbg_rdata, o_dbg_rvalid    registered DBG read data and its 1-cycle pulse
//   o_halted                     registered copy of "state is S_HALT"
//   o_ram_addr/data/we           RAM command from the granted requester, else 0
//   i_ram_data                   asynchronous RAM read data for o_ram_addr
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_data,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_stall,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_data,
  input  logic              i_dbg_halt,
  output logic              o_dbg_gnt,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic              o_dbg_rvalid,
  output logic              o_halted,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data,
  output logic              o_ram_we,
  input  logic [DATA_W-1:0] i_ram_data
);

  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_STREAK);

  arb_state_t          state_r;
  arb_state_t          state_next_s;
  logic [STREAK_W-1:0] streak_r;
  logic [STREAK_W-1:0] streak_next_s;
  logic                force_dbg_s;
  logic                cpu_gnt_s;
  logic                dbg_gnt_s;
  logic [DATA_W-1:0]   dbg_rdata_r;
  logic                dbg_rvalid_r;
  logic                halted_r;

  // Grant decision for the current cycle, based on the current state only.
  always_comb begin
    force_dbg_s = 1'b0;
    cpu_gnt_s   = 1'b0;
    dbg_gnt_s   = 1'b0;
    case (state_r)
      S_RUN: begin
        force_dbg_s = i_dbg_req & (streak_r == MAX_S);
        cpu_gnt_s   = i_cpu_req & ~force_dbg_s;
        dbg_gnt_s   = i_dbg_req & (~i_cpu_req | force_dbg_s);
      end
      S_HALT: begin
        dbg_gnt_s = i_dbg_req;
      end
      default: begin
        force_dbg_s = 1'b0;
        cpu_gnt_s   = 1'b0;
        dbg_gnt_s   = 1'b0;
      end
    endcase
  end

  // Next state and starvation-counter update.
  always_comb begin
    state_next_s  = state_r;
    streak_next_s = streak_r;
    case (state_r)
      S_RUN: begin
        if (i_dbg_halt) begin
          state_next_s = S_HALT;
        end else begin
          state_next_s = S_RUN;
        end
        // The streak only measures how long a waiting DBG has been passed over.
        if (!i_dbg_req || dbg_gnt_s) begin
          streak_next_s = 4'd0;
        end else if (cpu_gnt_s) begin
          streak_next_s = sat_inc(streak_r, MAX_S);
        end else begin
          streak_next_s = streak_r;
        end
      end
      S_HALT: begin
        if (i_dbg_halt) begin
          state_next_s = S_HALT;
        end else begin
          state_next_s = S_RUN;
        end
        streak_next_s = 4'd0;
      end
      default: begin
        state_next_s  = S_RUN;
        streak_next_s = 4'd0;
      end
    endcase
  end

  // State and streak registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= S_RUN;
      streak_r <= 4'd0;
    end else begin
      state_r  <= state_next_s;
      streak_r <= streak_next_s;
    end
  end

  // RAM command mux and CPU-side read data; writes are blocked during reset.
  always_comb begin
    o_ram_addr  = {ADDR_W{1'b0}};
    o_ram_data  = {DATA_W{1'b0}};
    o_ram_we    = 1'b0;
    o_cpu_rdata = {DATA_W{1'b0}};
    if (cpu_gnt_s) begin
      o_ram_addr  = i_cpu_addr;
      o_ram_data  = i_cpu_data;
      o_ram_we    = i_cpu_we & ~i_rst;
      o_cpu_rdata = i_ram_data;
    end else if (dbg_gnt_s) begin
      o_ram_addr = i_dbg_addr;
      o_ram_data = i_dbg_data;
      o_ram_we   = i_dbg_we & ~i_rst;
    end else begin
      o_ram_addr  = {ADDR_W{1'b0}};
      o_ram_data  = {DATA_W{1'b0}};
      o_ram_we    = 1'b0;
      o_cpu_rdata = {DATA_W{1'b0}};
    end
  end

  // DBG read capture: one rvalid pulse per granted read, one cycle later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dbg_rdata_r  <= {DATA_W{1'b0}};
      dbg_rvalid_r <= 1'b0;
    end else if (dbg_gnt_s && !i_dbg_we) begin
      dbg_rdata_r  <= i_ram_data;
      dbg_rvalid_r <= 1'b1;
    end else begin
      dbg_rdata_r  <= dbg_rdata_r;
      dbg_rvalid_r <= 1'b0;
    end
  end

  // Halt indicator lags the state register by one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      halted_r <= 1'b0;
    end else begin
      halted_r <= (state_r == S_HALT);
    end
  end

  assign o_cpu_stall  = i_cpu_req & ~cpu_gnt_s;
  assign o_dbg_gnt    = dbg_gnt_s;
  assign o_dbg_rdata  = dbg_rdata_r;
  assign o_dbg_rvalid = dbg_rvalid_r;
  assign o_halted     = halted_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a 64x32 behavioural RAM. A second
//   instance with MAX_STREAK=1 shares the stimulus to observe strict
//   alternation under contention.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [5:0]  cpu_addr;
  logic [31:0] cpu_data;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req;
  logic        dbg_we;
  logic [5:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_halt;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;
  logic        dbg_rvalid;
  logic        halted;
  logic [5:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;

  logic [31:0] d1_cpu_rdata;
  logic        d1_cpu_stall;
  logic        d1_dbg_gnt;
  logic [31:0] d1_dbg_rdata;
  logic        d1_dbg_rvalid;
  logic        d1_halted;
  logic [5:0]  d1_ram_addr;
  logic [31:0] d1_ram_wdata;
  logic        d1_ram_we;

  logic [31:0] ram [0:63];
  logic        ram_clr;

  int checks;
  int errors;

  dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_STREAK(4)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_data),
    .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_data(dbg_data),
    .i_dbg_halt(dbg_halt), .o_dbg_gnt(dbg_gnt), .o_dbg_rdata(dbg_rdata),
    .o_dbg_rvalid(dbg_rvalid), .o_halted(halted),
    .o_ram_addr(ram_addr), .o_ram_data(ram_wdata), .o_ram_we(ram_we),
    .i_ram_data(ram_rdata)
  );

  dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_STREAK(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_data),
    .o_cpu_rdata(d1_cpu_rdata), .o_cpu_stall(d1_cpu_stall),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_data(dbg_data),
    .i_dbg_halt(dbg_halt), .o_dbg_gnt(d1_dbg_gnt), .o_dbg_rdata(d1_dbg_rdata),
    .o_dbg_rvalid(d1_dbg_rvalid), .o_halted(d1_halted),
    .o_ram_addr(d1_ram_addr), .o_ram_data(d1_ram_wdata), .o_ram_we(d1_ram_we),
    .i_ram_data(32'h0000_0000)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: asynchronous read, write on the rising edge.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int k = 0; k < 64; k++) ram[k] <= 32'h0;
    end else if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = ram[ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ram_clr = 1'b1;
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd5; cpu_data = 32'hAAAA_5555;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 6'd0; dbg_data = 32'h0;
    dbg_halt = 1'b0;

    // 1. Reset held two cycles with a CPU store pending
    #1;
    chk("rst_we0", ram_we, 1'b0);
    tick();
    ram_clr = 1'b0;
    chk("rst_we1", ram_we, 1'b0);
    chk("rst_rvalid", dbg_rvalid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    tick();
    chk("rst_ram5", ram[5], 32'h0);
    rst = 1'b0;

    // 2. CPU store then load at address 5
    cpu_data = 32'hDEAD_BEEF;
    #1;
    chk("sw_stall", cpu_stall, 1'b0);
    chk("sw_we", ram_we, 1'b1);
    chk("sw_addr", ram_addr, 6'd5);
    chk("sw_data", ram_wdata, 32'hDEAD_BEEF);
    tick();
    chk("sw_ram5", ram[5], 32'hDEAD_BEEF);
    cpu_we = 1'b0;
    #1;
    chk("lw_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("lw_stall", cpu_stall, 1'b0);
    chk("lw_we", ram_we, 1'b0);
    tick();

    // Idle: RAM-side outputs all zero
    cpu_req = 1'b0;
    #1;
    chk("idle_addr", ram_addr, 6'd0);
    chk("idle_data", ram_wdata, 32'h0);
    chk("idle_we", ram_we, 1'b0);
    chk("idle_rdata", cpu_rdata, 32'h0);
    tick();

    // 3. Contention: four CPU grants then a forced DBG slot; MAX_STREAK=1 alternates
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd7;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd5;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i < 4) begin
        chk("cont_gnt0", dbg_gnt, 1'b0);
        chk("cont_stall0", cpu_stall, 1'b0);
      end else begin
        chk("cont_gnt1", dbg_gnt, 1'b1);
        chk("cont_stall1", cpu_stall, 1'b1);
        chk("cont_addr", ram_addr, 6'd5);
      end
      chk("ms1_alt", d1_dbg_gnt, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
    end
    dbg_req = 1'b0;
    #1;
    chk("cont_rvalid", dbg_rvalid, 1'b1);
    chk("cont_rdata", dbg_rdata, 32'hDEAD_BEEF);
    chk("cont_stall_after", cpu_stall, 1'b0);
    tick();
    chk("cont_rvalid_drop", dbg_rvalid, 1'b0);

    // 4. Halt: DBG loads addresses 0..3 while the CPU is stalled
    dbg_halt = 1'b1; cpu_addr = 6'd0;
    #1;
    chk("halt_trans_stall", cpu_stall, 1'b0);
    chk("halt_trans_halted", halted, 1'b0);
    tick();
    chk("halt_stall", cpu_stall, 1'b1);
    for (int i = 0; i < 4; i++) begin
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'(i); dbg_data = 32'h10 + 32'(i);
      #1;
      chk("halt_wgnt", dbg_gnt, 1'b1);
      chk("halt_wstall", cpu_stall, 1'b1);
      chk("halt_wwe", ram_we, 1'b1);
      chk("halt_halted", halted, (i > 0) ? 32'd1 : 32'd0);
      tick();
    end
    dbg_req = 1'b0; dbg_halt = 1'b0;
    #1;
    chk("rel_stall", cpu_stall, 1'b1);
    tick();
    chk("rel_halted_lag", halted, 1'b1);
    chk("rel_stall0", cpu_stall, 1'b0);
    chk("rel_lw0", cpu_rdata, 32'h10);
    tick();
    chk("rel_halted_fall", halted, 1'b0);
    cpu_addr = 6'd3;
    #1;
    chk("rel_lw3", cpu_rdata, 32'h13);
    tick();

    // 5. Back-to-back DBG reads of 1,2,3 with the CPU idle
    cpu_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd1;
    #1;
    chk("b2b_gnt", dbg_gnt, 1'b1);
    tick();
    dbg_addr = 6'd2;
    chk("b2b_v1", dbg_rvalid, 1'b1);
    chk("b2b_d1", dbg_rdata, 32'h11);
    tick();
    dbg_addr = 6'd3;
    chk("b2b_v2", dbg_rvalid, 1'b1);
    chk("b2b_d2", dbg_rdata, 32'h12);
    tick();
    dbg_req = 1'b0;
    chk("b2b_v3", dbg_rvalid, 1'b1);
    chk("b2b_d3", dbg_rdata, 32'h13);
    tick();
    chk("b2b_vend", dbg_rvalid, 1'b0);

    // 6. Reset the cycle after a DBG read grant while halted
    dbg_halt = 1'b1;
    tick();
    tick();
    chk("r6_halted", halted, 1'b1);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd2;
    #1;
    chk("r6_gnt", dbg_gnt, 1'b1);
    tick();
    rst = 1'b1; dbg_we = 1'b1; dbg_data = 32'hBAD0_BAD0;
    #1;
    chk("r6_we_sup", ram_we, 1'b0);
    tick();
    chk("r6_rvalid", dbg_rvalid, 1'b0);
    chk("r6_halted0", halted, 1'b0);
    chk("r6_ram2", ram[2], 32'h12);
    rst = 1'b0; dbg_halt = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd2;
    dbg_we = 1'b0; dbg_addr = 6'd3;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i < 4) begin
        chk("r6_run_stall", cpu_stall, 1'b0);
        chk("r6_streak_gnt0", dbg_gnt, 1'b0);
        chk("r6_lw2", cpu_rdata, 32'h12);
      end else begin
        chk("r6_streak_gnt1", dbg_gnt, 1'b1);
      end
      tick();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    #1;
    chk("r6_final_v", dbg_rvalid, 1'b1);
    chk("r6_final_d", dbg_rdata, 32'h13);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
